reorder_buffer: RTL and testbench

//  In-order retirement queue downstream of the reservation station and LSB. Allocates a ROB index per

---
 rtl/reorder_buffer_pkg.sv | 31 +++
 rtl/rob_idx_inc.sv | 9 +
 rtl/reorder_buffer.sv | 147 ++++++++++++++
 tb/tb_reorder_buffer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: RV32I opcode encodings and retirement classification helpers
package reorder_buffer_pkg;
    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111,
        OP_BRANCH = 7'b1100011,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_REG    = 7'b0110011
    } opcode_e;

    function automatic logic writes_reg(input logic [6:0] op);
        return op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_IMM, OP_REG};
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return op inside {OP_BRANCH, OP_JAL, OP_JALR};
    endfunction

    function automatic logic is_store(input logic [6:0] op);
        return op == OP_STORE;
    endfunction

    function automatic logic mispred(input logic pred_br, input logic [31:0] pred_target,
                                     input logic actual_br, input logic [31:0] pc_jump);
        return actual_br != pred_br || (actual_br && pc_jump != pred_target);
    endfunction
endpackage

// File: rtl/rob_idx_inc.sv
// rob_idx_inc: ROB index increment wrapping from all-ones back to 1, never producing 0
module rob_idx_inc #(
    parameter int W = 4
) (
    input  logic [W-1:0] idx,
    output logic [W-1:0] nxt
);
    always_comb nxt = &idx ? W'(1) : idx + W'(1);
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue with writeback capture, operand forwarding and mispredict flush
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_WIDTH = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    output logic                 rob_full,
    output logic [ROB_WIDTH-1:0] rob_next_index,
    input  logic                 issue_valid,
    input  logic [6:0]           issue_opcode,
    input  logic [4:0]           issue_rd,
    input  logic [31:0]          issue_pc,
    input  logic                 issue_pred_br,
    input  logic [31:0]          issue_pred_target,
    input  logic                 issue_done,
    input  logic [ROB_WIDTH-1:0] query1_index,
    output logic                 query1_ready,
    output logic [31:0]          query1_val,
    input  logic [ROB_WIDTH-1:0] query2_index,
    output logic                 query2_ready,
    output logic [31:0]          query2_val,
    input  logic                 rs_ready,
    input  logic [ROB_WIDTH-1:0] rs_rob_index,
    input  logic [31:0]          rs_val,
    input  logic                 rs_actual_br,
    input  logic [31:0]          rs_pc_jump,
    input  logic                 lsb_ready,
    input  logic [ROB_WIDTH-1:0] lsb_rob_index,
    input  logic [31:0]          lsb_val,
    output logic                 commit_reg_valid,
    output logic [4:0]           commit_rd,
    output logic [31:0]          commit_val,
    output logic [ROB_WIDTH-1:0] commit_rob_index,
    output logic                 commit_store,
    output logic                 commit_br_valid,
    output logic [31:0]          commit_br_pc,
    output logic                 commit_br_taken,
    output logic                 rob_clr,
    output logic [31:0]          rob_pc_redirect
);
    localparam int N = 2 ** ROB_WIDTH;
    localparam logic [ROB_WIDTH-1:0] IDX_FIRST = ROB_WIDTH'(1);

    logic [N-1:0] busy, done, pred_q, actual_q;
    logic [6:0] op_q [N];
    logic [4:0] rd_q [N];
    logic [31:0] val_q [N], pc_q [N], tgt_q [N], jump_q [N];
    logic [ROB_WIDTH-1:0] head, tail, count, head_nxt, tail_nxt;
    logic do_issue, do_commit, rs_hit, lsb_hit, flush;

    rob_idx_inc #(.W(ROB_WIDTH)) u_head_inc (.idx(head), .nxt(head_nxt));
    rob_idx_inc #(.W(ROB_WIDTH)) u_tail_inc (.idx(tail), .nxt(tail_nxt));

    // Inputs arriving while rob_clr is high belong to the squashed path and are dropped.
    always_comb begin
        rob_full = &count;
        rob_next_index = tail;
        do_issue = issue_valid && !rob_full && !rob_clr;
        do_commit = busy[head] && done[head];
        rs_hit = rs_ready && !rob_clr && rs_rob_index != '0 && busy[rs_rob_index];
        lsb_hit = lsb_ready && !rob_clr && lsb_rob_index != '0 && busy[lsb_rob_index];
        flush = do_commit && is_ctrl(op_q[head])
              && mispred(pred_q[head], tgt_q[head], actual_q[head], jump_q[head]);
    end

    function automatic logic [32:0] lookup(input logic [ROB_WIDTH-1:0] idx);
        return idx == '0 ? {1'b1, 32'h0}
             : rs_ready && rs_rob_index == idx ? {1'b1, rs_val}
             : lsb_ready && lsb_rob_index == idx ? {1'b1, lsb_val}
             : {done[idx], val_q[idx]};
    endfunction

    always_comb begin
        {query1_ready, query1_val} = lookup(query1_index);
        {query2_ready, query2_val} = lookup(query2_index);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head <= IDX_FIRST;
            tail <= IDX_FIRST;
            count <= '0;
            busy <= '0;
            done <= '0;
            commit_reg_valid <= 1'b0;
            commit_rd <= '0;
            commit_val <= '0;
            commit_rob_index <= '0;
            commit_store <= 1'b0;
            commit_br_valid <= 1'b0;
            commit_br_pc <= '0;
            commit_br_taken <= 1'b0;
            rob_clr <= 1'b0;
            rob_pc_redirect <= '0;
        end else if (rdy_in) begin
            commit_reg_valid <= do_commit && writes_reg(op_q[head]) && rd_q[head] != '0;
            commit_rd <= do_commit ? rd_q[head] : '0;
            commit_val <= do_commit ? val_q[head] : '0;
            commit_rob_index <= do_commit ? head : '0;
            commit_store <= do_commit && is_store(op_q[head]);
            commit_br_valid <= do_commit && is_ctrl(op_q[head]);
            commit_br_pc <= do_commit ? pc_q[head] : '0;
            commit_br_taken <= do_commit && is_ctrl(op_q[head]) && actual_q[head];
            rob_clr <= flush;
            rob_pc_redirect <= !flush ? '0 : actual_q[head] ? jump_q[head] : pc_q[head] + 32'd4;
            if (do_issue) begin
                busy[tail] <= 1'b1;
                done[tail] <= issue_done;
                op_q[tail] <= issue_opcode;
                rd_q[tail] <= issue_rd;
                pc_q[tail] <= issue_pc;
                pred_q[tail] <= issue_pred_br;
                tgt_q[tail] <= issue_pred_target;
                val_q[tail] <= '0;
                actual_q[tail] <= 1'b0;
                jump_q[tail] <= '0;
                tail <= tail_nxt;
            end
            if (rs_hit) begin
                done[rs_rob_index] <= 1'b1;
                val_q[rs_rob_index] <= rs_val;
                actual_q[rs_rob_index] <= rs_actual_br;
                jump_q[rs_rob_index] <= rs_pc_jump;
            end
            if (lsb_hit) begin
                done[lsb_rob_index] <= 1'b1;
                val_q[lsb_rob_index] <= lsb_val;
            end
            if (do_commit) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head <= head_nxt;
            end
            count <= count + ROB_WIDTH'(do_issue) - ROB_WIDTH'(do_commit);
            if (flush) begin
                busy <= '0;
                done <= '0;
                head <= IDX_FIRST;
                tail <= IDX_FIRST;
                count <= '0;
            end
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed and random checks of reorder_buffer against a queue-based model
module tb_reorder_buffer;
    localparam logic [6:0] T_LUI = 7'b0110111, T_AUIPC = 7'b0010111, T_JAL = 7'b1101111,
                           T_JALR = 7'b1100111, T_BR = 7'b1100011, T_LOAD = 7'b0000011,
                           T_ST = 7'b0100011, T_IMM = 7'b0010011, T_REG = 7'b0110011;

    logic clk_in = 1'b0;
    logic rst_in, rdy_in, issue_valid, issue_pred_br, issue_done;
    logic [6:0] issue_opcode;
    logic [4:0] issue_rd;
    logic [31:0] issue_pc, issue_pred_target;
    logic [3:0] query1_index, query2_index, rs_rob_index, lsb_rob_index;
    logic rs_ready, rs_actual_br, lsb_ready;
    logic [31:0] rs_val, rs_pc_jump, lsb_val;
    logic rob_full, query1_ready, query2_ready, commit_reg_valid, commit_store;
    logic commit_br_valid, commit_br_taken, rob_clr;
    logic [3:0] rob_next_index, commit_rob_index;
    logic [4:0] commit_rd;
    logic [31:0] query1_val, query2_val, commit_val, commit_br_pc, rob_pc_redirect;

    int checks = 0;
    int errors = 0;

    reorder_buffer #(.ROB_WIDTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .rob_full(rob_full), .rob_next_index(rob_next_index),
        .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_rd(issue_rd),
        .issue_pc(issue_pc), .issue_pred_br(issue_pred_br),
        .issue_pred_target(issue_pred_target), .issue_done(issue_done),
        .query1_index(query1_index), .query1_ready(query1_ready), .query1_val(query1_val),
        .query2_index(query2_index), .query2_ready(query2_ready), .query2_val(query2_val),
        .rs_ready(rs_ready), .rs_rob_index(rs_rob_index), .rs_val(rs_val),
        .rs_actual_br(rs_actual_br), .rs_pc_jump(rs_pc_jump),
        .lsb_ready(lsb_ready), .lsb_rob_index(lsb_rob_index), .lsb_val(lsb_val),
        .commit_reg_valid(commit_reg_valid), .commit_rd(commit_rd), .commit_val(commit_val),
        .commit_rob_index(commit_rob_index), .commit_store(commit_store),
        .commit_br_valid(commit_br_valid), .commit_br_pc(commit_br_pc),
        .commit_br_taken(commit_br_taken), .rob_clr(rob_clr), .rob_pc_redirect(rob_pc_redirect)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int idx;
        logic [6:0] op;
        logic [4:0] rd;
        logic [31:0] pc;
        logic pbr;
        logic [31:0] ptgt;
        logic done;
        logic [31:0] val;
        logic abr;
        logic [31:0] jmp;
    } ent_t;

    ent_t q[$];
    int m_tail = 1;
    logic e_rv, e_st, e_brv, e_brt, e_clr;
    logic [4:0] e_rd;
    logic [31:0] e_val, e_brpc, e_redir;
    int e_idx;
    logic [6:0] ops [9] = '{T_LUI, T_AUIPC, T_JAL, T_JALR, T_BR, T_LOAD, T_ST, T_IMM, T_REG};

    function automatic bit is_br(input logic [6:0] op);
        return op == T_BR || op == T_JAL || op == T_JALR;
    endfunction

    function automatic bit writes(input logic [6:0] op);
        return op != T_BR && op != T_ST;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue model: head is q[0]; retirement order and index assignment follow from arithmetic.
    task automatic model_edge();
        ent_t h;
        bit c, full;
        if (rst_in) begin
            q.delete();
            m_tail = 1;
            {e_rv, e_st, e_brv, e_brt, e_clr} = '0;
            e_rd = 0; e_val = 0; e_brpc = 0; e_redir = 0; e_idx = 0;
        end else if (rdy_in) begin
            full = q.size() == 15;
            c = q.size() > 0 && q[0].done;
            if (c) h = q[0];
            {e_rv, e_st, e_brv, e_brt} = '0;
            e_rd = 0; e_val = 0; e_brpc = 0; e_idx = 0;
            if (e_clr) begin
                e_clr = 0;
                e_redir = 0;
            end else begin
                foreach (q[i]) begin
                    if (rs_ready && q[i].idx == int'(rs_rob_index)) begin
                        q[i].done = 1; q[i].val = rs_val; q[i].abr = rs_actual_br; q[i].jmp = rs_pc_jump;
                    end
                    if (lsb_ready && q[i].idx == int'(lsb_rob_index)) begin
                        q[i].done = 1; q[i].val = lsb_val;
                    end
                end
                if (c) begin
                    void'(q.pop_front());
                    e_rv = writes(h.op) && h.rd != 0;
                    e_rd = h.rd; e_val = h.val; e_idx = h.idx; e_brpc = h.pc;
                    e_st = h.op == T_ST;
                    e_brv = is_br(h.op);
                    e_brt = is_br(h.op) && h.abr;
                    if (is_br(h.op) && (h.abr != h.pbr || (h.abr && h.jmp != h.ptgt))) begin
                        e_clr = 1;
                        e_redir = h.abr ? h.jmp : h.pc + 4;
                    end
                end
                if (issue_valid && !full) begin
                    q.push_back('{m_tail, issue_opcode, issue_rd, issue_pc, issue_pred_br,
                                  issue_pred_target, issue_done, 32'h0, 1'b0, 32'h0});
                    m_tail = m_tail == 15 ? 1 : m_tail + 1;
                end
                if (e_clr) begin
                    q.delete();
                    m_tail = 1;
                end
            end
        end
    endtask

    function automatic bit qexp(input logic [3:0] idx, output logic r, output logic [31:0] v);
        r = 1; v = 0;
        if (idx == 0) return 1;
        if (rs_ready && rs_rob_index == idx) begin v = rs_val; return 1; end
        if (lsb_ready && lsb_rob_index == idx) begin v = lsb_val; return 1; end
        foreach (q[i]) if (q[i].idx == int'(idx)) begin r = q[i].done; v = q[i].val; return 1; end
        return 0;
    endfunction

    task automatic step();
        logic r;
        logic [31:0] v;
        #1;
        if (qexp(query1_index, r, v)) begin chk("q1_ready", query1_ready, r); chk("q1_val", query1_val, v); end
        if (qexp(query2_index, r, v)) begin chk("q2_ready", query2_ready, r); chk("q2_val", query2_val, v); end
        model_edge();
        @(posedge clk_in);
        #1;
        chk("reg_valid", commit_reg_valid, e_rv);
        chk("rd", commit_rd, e_rd);
        chk("val", commit_val, e_val);
        chk("rob_index", commit_rob_index, e_idx);
        chk("store", commit_store, e_st);
        chk("br_valid", commit_br_valid, e_brv);
        chk("br_pc", commit_br_pc, e_brpc);
        chk("br_taken", commit_br_taken, e_brt);
        chk("clr", rob_clr, e_clr);
        chk("redirect", rob_pc_redirect, e_redir);
        chk("full", rob_full, q.size() == 15);
        chk("next_index", rob_next_index, m_tail);
        @(negedge clk_in);
    endtask

    task automatic idle();
        rst_in = 0; rdy_in = 1;
        issue_valid = 0; issue_opcode = 0; issue_rd = 0; issue_pc = 0;
        issue_pred_br = 0; issue_pred_target = 0; issue_done = 0;
        query1_index = 0; query2_index = 0;
        rs_ready = 0; rs_rob_index = 0; rs_val = 0; rs_actual_br = 0; rs_pc_jump = 0;
        lsb_ready = 0; lsb_rob_index = 0; lsb_val = 0;
    endtask

    task automatic iss(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] pc,
                       input logic pbr, input logic [31:0] ptgt, input logic dn);
        issue_valid = 1; issue_opcode = op; issue_rd = rd; issue_pc = pc;
        issue_pred_br = pbr; issue_pred_target = ptgt; issue_done = dn;
    endtask

    task automatic rand_inputs();
        int k;
        logic [6:0] op;
        idle();
        op = ops[$urandom_range(0, 8)];
        iss(op, 5'($urandom), $urandom & 32'hfffc, 0, 0, 0);
        issue_valid = $urandom_range(0, 3) != 0;
        if (is_br(op)) begin
            issue_pred_br = 1'($urandom_range(0, 1));
            issue_pred_target = $urandom & 32'hfffc;
        end
        issue_done = (op == T_LUI || op == T_AUIPC) && $urandom_range(0, 1) == 1;
        query1_index = 4'($urandom);
        query2_index = 4'($urandom);
        if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, q.size() - 1);
            rs_ready = 1; rs_rob_index = 4'(q[k].idx); rs_val = $urandom;
            if (is_br(q[k].op)) begin
                rs_actual_br = $urandom_range(0, 4) == 0 ? !q[k].pbr : q[k].pbr;
                rs_pc_jump = $urandom_range(0, 4) == 0 ? $urandom & 32'hfffc : q[k].ptgt;
            end
        end else if ($urandom_range(0, 3) == 0) begin
            rs_ready = 1; rs_rob_index = 4'($urandom); rs_val = $urandom;
        end
        if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            k = $urandom_range(0, q.size() - 1);
            if (!rs_ready || 4'(q[k].idx) != rs_rob_index) begin
                lsb_ready = 1; lsb_rob_index = 4'(q[k].idx); lsb_val = $urandom;
            end
        end
    endtask

    initial begin
        idle(); rst_in = 1; step(); step();
        chk("rst_next_index", rob_next_index, 1);
        chk("rst_full", rob_full, 0);
        chk("rst_clr", rob_clr, 0);
        chk("rst_reg_valid", commit_reg_valid, 0);

        idle(); iss(T_IMM, 5, 0, 0, 0, 0); step();
        chk("addi_next_index", rob_next_index, 2);
        idle(); rs_ready = 1; rs_rob_index = 1; rs_val = 7; step();
        chk("addi_no_early_commit", commit_reg_valid, 0);
        idle(); step();
        chk("addi_reg_valid", commit_reg_valid, 1);
        chk("addi_rd", commit_rd, 5);
        chk("addi_val", commit_val, 7);
        chk("addi_rob_index", commit_rob_index, 1);

        idle(); rst_in = 1; step();
        for (int i = 1; i <= 14; i++) begin idle(); iss(T_IMM, 5'(i), 32'(i * 4), 0, 0, 0); step(); end
        chk("fill14_full", rob_full, 0);
        chk("fill14_next", rob_next_index, 15);
        idle(); iss(T_IMM, 15, 'h3c, 0, 0, 0); step();
        chk("fill15_full", rob_full, 1);
        chk("fill15_wrap", rob_next_index, 1);
        idle(); iss(T_IMM, 16, 'h40, 0, 0, 0); step();
        chk("issue_when_full_ignored", rob_next_index, 1);
        idle(); iss(T_IMM, 17, 'h44, 0, 0, 0); rs_ready = 1; rs_rob_index = 1; rs_val = 'h11; step();
        idle(); iss(T_IMM, 18, 'h48, 0, 0, 0); step();
        chk("full_commit_index", commit_rob_index, 1);
        chk("full_commit_refused_issue", rob_next_index, 1);
        chk("full_commit_not_full", rob_full, 0);

        idle(); iss(T_IMM, 9, 'h80, 0, 0, 0);
        rs_ready = 1; rs_rob_index = 3; rs_val = 'h55; query1_index = 3; query2_index = 0; #1;
        chk("fwd_ready", query1_ready, 1);
        chk("fwd_val", query1_val, 'h55);
        chk("idx0_ready", query2_ready, 1);
        chk("idx0_val", query2_val, 0);
        step();
        idle(); rs_ready = 1; rs_rob_index = 2; rs_val = 'h22; step();
        idle(); step();
        idle(); iss(T_IMM, 10, 'h84, 0, 0, 0); step();
        chk("commit_issue_index", commit_rob_index, 3);
        chk("commit_issue_next", rob_next_index, 3);
        chk("commit_issue_full", rob_full, 0);

        idle(); rst_in = 1; step();
        idle(); iss(T_BR, 0, 'h100, 0, 0, 0); step();
        idle(); rs_ready = 1; rs_rob_index = 1; rs_actual_br = 1; rs_pc_jump = 'h140; step();
        idle(); iss(T_IMM, 3, 'h104, 0, 0, 0); step();
        chk("beq_br_valid", commit_br_valid, 1);
        chk("beq_taken", commit_br_taken, 1);
        chk("beq_clr", rob_clr, 1);
        chk("beq_redirect", rob_pc_redirect, 'h140);
        idle(); iss(T_IMM, 3, 'h140, 0, 0, 0); step();
        chk("beq_after_clr", rob_clr, 0);
        chk("beq_after_next", rob_next_index, 1);

        idle(); iss(T_JALR, 1, 'h300, 1, 'h200, 0); step();
        idle(); rs_ready = 1; rs_rob_index = 1; rs_val = 'h304; rs_actual_br = 1; rs_pc_jump = 'h204; step();
        idle(); step();
        chk("jalr_clr", rob_clr, 1);
        chk("jalr_redirect", rob_pc_redirect, 'h204);
        chk("jalr_reg_valid", commit_reg_valid, 1);
        idle(); step();
        idle(); iss(T_JALR, 2, 'h400, 1, 'h200, 0); step();
        idle(); rs_ready = 1; rs_rob_index = 1; rs_val = 'h404; rs_actual_br = 1; rs_pc_jump = 'h200; step();
        idle(); step();
        chk("jalr_ok_clr", rob_clr, 0);
        chk("jalr_ok_reg_valid", commit_reg_valid, 1);

        idle(); iss(T_ST, 0, 'h500, 0, 0, 0); step();
        idle(); lsb_ready = 1; lsb_rob_index = 2; lsb_val = 'hdead; step();
        idle(); step();
        chk("store_commit", commit_store, 1);
        chk("store_no_reg", commit_reg_valid, 0);

        idle(); iss(T_IMM, 7, 'h600, 0, 0, 1); step();
        idle(); step();
        for (int i = 0; i < 3; i++) begin
            idle(); rdy_in = 0; iss(T_IMM, 8, 'h604, 0, 0, 1); step();
            chk("rdy_low_pulse_held", commit_reg_valid, 1);
            chk("rdy_low_next_held", rob_next_index, 4);
        end
        idle(); step();
        chk("rdy_back_pulse_done", commit_reg_valid, 0);

        idle(); iss(T_IMM, 8, 'h700, 0, 0, 1); step();
        idle(); iss(T_IMM, 9, 'h704, 0, 0, 1); rst_in = 1; step();
        chk("midrst_next", rob_next_index, 1);
        idle(); step();
        chk("midrst_no_commit", commit_reg_valid, 0);

        for (int n = 0; n < 3000; n++) begin
            rand_inputs();
            rdy_in = $urandom_range(0, 9) != 0;
            rst_in = $urandom_range(0, 299) == 0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
